// File: rtl/mips_exec_stage.sv
// Execute stage for the multicycle MIPS: ALU-control decode, 32-bit ALU, branch-target adder; outputs registered 1 cycle after en.
// No backpressure (en is a capture strobe). Optional EXEC_OVF_EN adds trapping ADD/SUB codes and a registered ovf flag.
module mips_exec_stage #(
   parameter int BRANCH_SHIFT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [3:0]  alu_op,
   input  logic [5:0]  funct,
   input  logic [4:0]  branchz_func,
   input  logic [4:0]  shamt,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] pc,
   input  logic [15:0] imm,
   output logic [4:0]  alu_ctrl,
   output logic [31:0] result,
   output logic        zero,
   output logic [31:0] branch_target,
`ifdef EXEC_OVF_EN
   output logic        ovf,
`endif
   output logic        valid
);

   localparam logic [4:0] C_ADD  = 5'd0,  C_SUB  = 5'd1,  C_AND  = 5'd2,  C_OR   = 5'd3;
   localparam logic [4:0] C_XOR  = 5'd4,  C_NOR  = 5'd5,  C_SLT  = 5'd6,  C_SLTU = 5'd7;
   localparam logic [4:0] C_SLL  = 5'd8,  C_SRL  = 5'd9,  C_SRA  = 5'd10, C_SLLV = 5'd11;
   localparam logic [4:0] C_SRLV = 5'd12, C_SRAV = 5'd13, C_LUI  = 5'd14, C_PASSA = 5'd15;
   localparam logic [4:0] C_EQ   = 5'd16, C_NE   = 5'd17, C_LTZ  = 5'd18, C_GEZ  = 5'd19;
   localparam logic [4:0] C_LEZ  = 5'd20, C_GTZ  = 5'd21;
`ifdef EXEC_OVF_EN
   localparam logic [4:0] C_ADDS = 5'd22, C_SUBS = 5'd23;
`endif

   logic [4:0]  funct_ctrl;
   logic [4:0]  regimm_ctrl;
   logic [31:0] sum, diff, res_n, sext_imm, target_n;
   logic        zero_n, ovf_n;

   always_comb begin
      funct_ctrl = C_ADD;
      case (funct)
         6'h00: funct_ctrl = C_SLL;
         6'h02: funct_ctrl = C_SRL;
         6'h03: funct_ctrl = C_SRA;
         6'h04: funct_ctrl = C_SLLV;
         6'h06: funct_ctrl = C_SRLV;
         6'h07: funct_ctrl = C_SRAV;
         6'h08, 6'h09: funct_ctrl = C_PASSA;
`ifdef EXEC_OVF_EN
         6'h20: funct_ctrl = C_ADDS;
         6'h22: funct_ctrl = C_SUBS;
`else
         6'h20: funct_ctrl = C_ADD;
         6'h22: funct_ctrl = C_SUB;
`endif
         6'h21: funct_ctrl = C_ADD;
         6'h23: funct_ctrl = C_SUB;
         6'h24: funct_ctrl = C_AND;
         6'h25: funct_ctrl = C_OR;
         6'h26: funct_ctrl = C_XOR;
         6'h27: funct_ctrl = C_NOR;
         6'h2A: funct_ctrl = C_SLT;
         6'h2B: funct_ctrl = C_SLTU;
         default: funct_ctrl = C_ADD;
      endcase
   end

   always_comb begin
      regimm_ctrl = C_ADD;
      case (branchz_func)
         5'b00000, 5'b10000: regimm_ctrl = C_LTZ;
         5'b00001, 5'b10001: regimm_ctrl = C_GEZ;
         default:            regimm_ctrl = C_ADD;
      endcase
   end

   always_comb begin
      alu_ctrl = C_ADD;
      case (alu_op)
         4'd1:    alu_ctrl = C_EQ;
         4'd2:    alu_ctrl = funct_ctrl;
         4'd3:    alu_ctrl = C_AND;
         4'd4:    alu_ctrl = C_OR;
         4'd5:    alu_ctrl = C_XOR;
         4'd6:    alu_ctrl = C_SLT;
         4'd7:    alu_ctrl = C_SLTU;
         4'd9:    alu_ctrl = C_NE;
         4'd10:   alu_ctrl = regimm_ctrl;
         4'd11:   alu_ctrl = C_LEZ;
         4'd12:   alu_ctrl = C_GTZ;
         4'd13:   alu_ctrl = C_LUI;
         default: alu_ctrl = C_ADD;
      endcase
   end

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      res_n  = sum;
      ovf_n  = 1'b0;
      case (alu_ctrl)
         C_SUB:   res_n = diff;
         C_AND:   res_n = a & b;
         C_OR:    res_n = a | b;
         C_XOR:   res_n = a ^ b;
         C_NOR:   res_n = ~(a | b);
         C_SLT:   res_n = {31'b0, $signed(a) < $signed(b)};
         C_SLTU:  res_n = {31'b0, a < b};
         C_SLL:   res_n = b << shamt;
         C_SRL:   res_n = b >> shamt;
         C_SRA:   res_n = $signed(b) >>> shamt;
         C_SLLV:  res_n = b << a[4:0];
         C_SRLV:  res_n = b >> a[4:0];
         C_SRAV:  res_n = $signed(b) >>> a[4:0];
         C_LUI:   res_n = {imm, 16'h0000};
         C_PASSA: res_n = a;
         C_EQ, C_NE, C_LTZ, C_GEZ, C_LEZ, C_GTZ: res_n = diff;
`ifdef EXEC_OVF_EN
         C_ADDS: begin
            res_n = sum;
            ovf_n = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         C_SUBS: begin
            res_n = diff;
            ovf_n = (a[31] != b[31]) && (diff[31] != a[31]);
         end
`endif
         default: res_n = sum;
      endcase
   end

   // Branch codes report the condition on zero; everything else reports result == 0.
   always_comb begin
      zero_n = (res_n == 32'h0);
      case (alu_ctrl)
         C_EQ:    zero_n = (a == b);
         C_NE:    zero_n = (a != b);
         C_LTZ:   zero_n = a[31];
         C_GEZ:   zero_n = !a[31];
         C_LEZ:   zero_n = a[31] || (a == 32'h0);
         C_GTZ:   zero_n = !a[31] && (a != 32'h0);
         default: zero_n = (res_n == 32'h0);
      endcase
   end

   assign sext_imm = {{16{imm[15]}}, imm};
   assign target_n = pc + (sext_imm << BRANCH_SHIFT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result        <= '0;
         zero          <= 1'b0;
         branch_target <= '0;
         valid         <= 1'b0;
`ifdef EXEC_OVF_EN
         ovf           <= 1'b0;
`endif
      end else begin
         valid <= en;
         if (en) begin
            result        <= res_n;
            zero          <= zero_n;
            branch_target <= target_n;
`ifdef EXEC_OVF_EN
            ovf           <= ovf_n;
`endif
         end
      end
   end

`ifndef EXEC_OVF_EN
   logic unused_ovf;
   assign unused_ovf = ovf_n;
`endif

endmodule

// File: tb/tb_mips_exec_stage.sv
// Directed-vector bench for mips_exec_stage; expected responses queued at issue and checked by an output monitor.
module tb_mips_exec_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  alu_op = '0;
   logic [5:0]  funct = '0;
   logic [4:0]  branchz_func = '0;
   logic [4:0]  shamt = '0;
   logic [31:0] a = '0, b = '0, pc = '0;
   logic [15:0] imm = '0;
   logic [4:0]  alu_ctrl;
   logic [31:0] result, branch_target;
   logic        zero, valid;
`ifdef EXEC_OVF_EN
   logic        ovf;
`endif

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic [31:0] tgt;
      logic        ov;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad = 0;
   logic [31:0] last_res;

   mips_exec_stage #(.BRANCH_SHIFT(2)) dut (
      .clk(clk), .reset(reset), .en(en), .alu_op(alu_op), .funct(funct),
      .branchz_func(branchz_func), .shamt(shamt), .a(a), .b(b), .pc(pc), .imm(imm),
      .alu_ctrl(alu_ctrl), .result(result), .zero(zero), .branch_target(branch_target),
`ifdef EXEC_OVF_EN
      .ovf(ovf),
`endif
      .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per valid output beat.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result", result, e.res);
            check("zero", {31'b0, zero}, {31'b0, e.z});
            check("branch_target", branch_target, e.tgt);
`ifdef EXEC_OVF_EN
            check("ovf", {31'b0, ovf}, {31'b0, e.ov});
`endif
            last_res = result;
         end
      end
   end

   task automatic drive(input logic [3:0] op, input logic [5:0] f, input logic [4:0] bz,
                        input logic [4:0] sh, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vpc, input logic [15:0] vimm);
      @(negedge clk);
      alu_op = op; funct = f; branchz_func = bz; shamt = sh;
      a = va; b = vb; pc = vpc; imm = vimm; en = 1'b1;
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [5:0] f, input logic [4:0] bz,
                        input logic [4:0] sh, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vpc, input logic [15:0] vimm,
                        input logic [4:0] ectrl, input logic [31:0] eres, input logic ez,
                        input logic [31:0] etgt, input logic eov);
      exp_t e;
      drive(op, f, bz, sh, va, vb, vpc, vimm);
      check("alu_ctrl", {27'b0, alu_ctrl}, {27'b0, ectrl});
      e.res = eres; e.z = ez; e.tgt = etgt; e.ov = eov;
      exp_q.push_back(e);
   endtask

   localparam logic [31:0] PC0 = 32'h0040_0010;

   initial begin
      #12;
      check("reset_result", result, 32'h0);
      check("reset_valid", {31'b0, valid}, 32'h0);
      check("reset_target", branch_target, 32'h0);
      reset = 1'b1;

      //     op     funct  bz      sh    a              b              pc   imm       ctrl    result         z     target        ovf
      issue(4'd2,  6'h23, 5'h00,  5'd0, 32'd5,         32'd7,         PC0, 16'hFFFC, 5'd1,  32'hFFFFFFFE,  1'b0, 32'h00400000, 1'b0);
      issue(4'd2,  6'h03, 5'h00,  5'd4, 32'd0,         32'h80000000,  PC0, 16'hFFFC, 5'd10, 32'hF8000000,  1'b0, 32'h00400000, 1'b0);
      issue(4'd2,  6'h2A, 5'h00,  5'd0, 32'hFFFFFFFF,  32'd1,         PC0, 16'hFFFC, 5'd6,  32'd1,         1'b0, 32'h00400000, 1'b0);
      issue(4'd2,  6'h2B, 5'h00,  5'd0, 32'hFFFFFFFF,  32'd1,         PC0, 16'hFFFC, 5'd7,  32'd0,         1'b1, 32'h00400000, 1'b0);
      issue(4'd1,  6'h00, 5'h00,  5'd0, 32'h1234,      32'h1234,      PC0, 16'h0003, 5'd16, 32'd0,         1'b1, 32'h0040001C, 1'b0);
      issue(4'd9,  6'h00, 5'h00,  5'd0, 32'h1234,      32'h1234,      PC0, 16'h0003, 5'd17, 32'd0,         1'b0, 32'h0040001C, 1'b0);
      issue(4'd10, 6'h00, 5'h10,  5'd0, 32'h80000000,  32'd0,         PC0, 16'h0003, 5'd18, 32'h80000000,  1'b1, 32'h0040001C, 1'b0);
      issue(4'd13, 6'h00, 5'h00,  5'd0, 32'd0,         32'd0,         PC0, 16'h0003, 5'd14, 32'h00030000,  1'b0, 32'h0040001C, 1'b0);
      issue(4'd2,  6'h27, 5'h00,  5'd0, 32'd0,         32'd0,         PC0, 16'h0003, 5'd5,  32'hFFFFFFFF,  1'b0, 32'h0040001C, 1'b0);
      issue(4'd2,  6'h04, 5'h00,  5'd0, 32'h24,        32'd1,         PC0, 16'h0003, 5'd11, 32'h10,        1'b0, 32'h0040001C, 1'b0);
      issue(4'd2,  6'h08, 5'h00,  5'd0, 32'd0,         32'd5,         PC0, 16'h0003, 5'd15, 32'd0,         1'b1, 32'h0040001C, 1'b0);
      issue(4'd11, 6'h00, 5'h00,  5'd0, 32'd0,         32'd0,         PC0, 16'hFFFC, 5'd20, 32'd0,         1'b1, 32'h00400000, 1'b0);
      issue(4'd12, 6'h00, 5'h00,  5'd0, 32'd0,         32'd0,         PC0, 16'hFFFC, 5'd21, 32'd0,         1'b0, 32'h00400000, 1'b0);
      issue(4'd2,  6'h3F, 5'h00,  5'd0, 32'd1,         32'd2,         PC0, 16'hFFFC, 5'd0,  32'd3,         1'b0, 32'h00400000, 1'b0);
      issue(4'd10, 6'h00, 5'h01,  5'd0, 32'd5,         32'd3,         PC0, 16'hFFFC, 5'd19, 32'd2,         1'b1, 32'h00400000, 1'b0);
      issue(4'd0,  6'h00, 5'h00,  5'd0, 32'hFFFFFFFF,  32'd1,         PC0, 16'hFFFC, 5'd0,  32'd0,         1'b1, 32'h00400000, 1'b0);
      issue(4'd2,  6'h02, 5'h00,  5'd4, 32'd0,         32'h80000000,  PC0, 16'hFFFC, 5'd9,  32'h08000000,  1'b0, 32'h00400000, 1'b0);
`ifdef EXEC_OVF_EN
      issue(4'd2,  6'h20, 5'h00,  5'd0, 32'h7FFFFFFF,  32'd1,         PC0, 16'hFFFC, 5'd22, 32'h80000000,  1'b0, 32'h00400000, 1'b1);
`else
      issue(4'd2,  6'h20, 5'h00,  5'd0, 32'h7FFFFFFF,  32'd1,         PC0, 16'hFFFC, 5'd0,  32'h80000000,  1'b0, 32'h00400000, 1'b0);
`endif
      issue(4'd2,  6'h21, 5'h00,  5'd0, 32'h7FFFFFFF,  32'd1,         PC0, 16'hFFFC, 5'd0,  32'h80000000,  1'b0, 32'h00400000, 1'b0);

      // Idle with en=0: valid drops and result holds the last capture.
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      #1;
      check("idle_valid", {31'b0, valid}, 32'h0);
      check("idle_hold", result, 32'h80000000);
      check("queue_drained", exp_q.size(), 32'd0);

      // Asynchronous reset mid-cycle after capturing 0xDEADBEEF.
      drive(4'd0, 6'h00, 5'h00, 5'd0, 32'hDEADBEEF, 32'd0, PC0, 16'h0003);
      @(posedge clk);
      #2;
      check("pre_reset_result", result, 32'hDEADBEEF);
      reset = 1'b0;
      #1;
      check("arst_result", result, 32'h0);
      check("arst_zero", {31'b0, zero}, 32'h0);
      check("arst_target", branch_target, 32'h0);
      check("arst_valid", {31'b0, valid}, 32'h0);
      en = 1'b0;
      #3;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_result", result, 32'h0);
      check("post_reset_target", branch_target, 32'h0);
      check("post_reset_valid", {31'b0, valid}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
